pps_disciplined_timebase: RTL and testbench

- Parametrised successor to the fixed MCLK/50 Hz timing generator.
- Produces the ADC master clock (MCLK) and a reporting-rate strobe (PULSE_OUT) from one system clock.
- Both outputs are phase-aligned to validated GPS_PPS edges. Includes PPS period checking, glitch rejection, holdover and lock status.
- Sits between the PLL output and the ADC interface/phasor estimator.

---
 rtl/pps_disciplined_timebase.sv | 191 +++++++++++++++++++
 tb/tb_pps_disciplined_timebase.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pps_disciplined_timebase.sv
// Purpose: MCLK and reporting-rate strobe generator phase-aligned to validated GPS PPS edges, with lock/holdover tracking.
// Latency: GPS_PPS rise -> aligned PULSE_OUT/MCLK on the 3rd CLK edge after the first edge sampling it high; status is registered.
// Backpressure: none; outputs free-run in every state and never stall.
`timescale 1ns/1ps
module pps_disciplined_timebase #(
    parameter int CLK_FREQ_HZ  = 32768000,
    parameter int MCLK_DIV     = 4,
    parameter int REPORT_RATE  = 50,
    parameter int PPS_TOL      = 1000,
    parameter int HOLDOVER_MAX = 10
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        GPS_PPS,
    output logic        MCLK,
    output logic        PULSE_OUT,
    output logic        PPS_LOCKED,
    output logic        HOLDOVER,
    output logic        PPS_ERR,
    output logic [31:0] PPS_PERIOD
);

    localparam int RPT_PERIOD = CLK_FREQ_HZ / REPORT_RATE;
    localparam int PH_W       = $clog2(MCLK_DIV);
    localparam int RPT_W      = (RPT_PERIOD > 1) ? $clog2(RPT_PERIOD) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(MCLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(MCLK_DIV / 2);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_PERIOD - 1);
    localparam logic [31:0]      WIN_LO   = 32'(CLK_FREQ_HZ - PPS_TOL);
    localparam logic [31:0]      WIN_HI   = 32'(CLK_FREQ_HZ + PPS_TOL);
    localparam logic [31:0]      SEC_LAST = 32'(CLK_FREQ_HZ - 1);
    localparam logic [31:0]      HO_LAST  = 32'(HOLDOVER_MAX - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        pps_sync;
    logic              ppsev;
    logic [PH_W-1:0]   mclk_ph;
    logic [PH_W-1:0]   mclk_ph_nxt;
    logic [RPT_W-1:0]  rpt_cnt;
    logic [RPT_W-1:0]  rpt_cnt_nxt;
    logic [31:0]       sec_cnt;
    logic [31:0]       sec_cnt_nxt;
    logic [31:0]       ho_cyc;
    logic [31:0]       ho_sec;
    logic              align;
    logic              err_nxt;
    logic              period_ld;
    logic              in_window;
    logic              late;
    logic              ho_expire;

    // Two-stage synchroniser plus a third stage for a registered one-cycle rising-edge event
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pps_sync <= 3'b000;
            ppsev    <= 1'b0;
        end else begin
            pps_sync <= {pps_sync[1:0], GPS_PPS};
            ppsev    <= pps_sync[1] & ~pps_sync[2];
        end
    end

    assign in_window = (sec_cnt >= WIN_LO) && (sec_cnt <= WIN_HI);
    assign late      = (sec_cnt > WIN_HI);
    assign ho_expire = (ho_cyc == SEC_LAST) && (ho_sec == HO_LAST);

    // Lock FSM: an edge inside the window always wins over the timeout on the same cycle
    always_comb begin
        state_nxt = state;
        align     = 1'b0;
        err_nxt   = 1'b0;
        period_ld = 1'b0;
        case (state)
            ST_UNLOCKED: begin
                if (ppsev) begin
                    align     = 1'b1;
                    state_nxt = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (ppsev) begin
                    align = 1'b1;
                    if (in_window) begin
                        period_ld = 1'b1;
                        state_nxt = ST_LOCKED;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (late) begin
                    state_nxt = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (ppsev && in_window) begin
                    align     = 1'b1;
                    period_ld = 1'b1;
                end else if (late) begin
                    // An edge landing exactly on the timeout cycle is past the window: reject it
                    state_nxt = ST_HOLDOVER;
                    err_nxt   = ppsev;
                end else if (ppsev) begin
                    // Early edge while locked is a glitch: keep the grid and the running period count
                    err_nxt = 1'b1;
                end
            end
            ST_HOLDOVER: begin
                if (ppsev) begin
                    align     = 1'b1;
                    state_nxt = ST_ACQUIRE;
                end else if (ho_expire) begin
                    state_nxt = ST_UNLOCKED;
                end
            end
            default: state_nxt = ST_UNLOCKED;
        endcase
    end

    // Next values of the free-running counters; alignment forces all of them to zero
    always_comb begin
        mclk_ph_nxt = (mclk_ph == PH_LAST) ? '0 : mclk_ph + 1'b1;
        rpt_cnt_nxt = (rpt_cnt == RPT_LAST) ? '0 : rpt_cnt + 1'b1;
        sec_cnt_nxt = (sec_cnt == 32'hFFFF_FFFF) ? sec_cnt : sec_cnt + 32'd1;
        if (align) begin
            mclk_ph_nxt = '0;
            rpt_cnt_nxt = '0;
            sec_cnt_nxt = '0;
        end
    end

    // Counters and the output clock/strobe; a wrap and an alignment together still give one strobe
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mclk_ph   <= '0;
            rpt_cnt   <= '0;
            sec_cnt   <= '0;
            MCLK      <= 1'b0;
            PULSE_OUT <= 1'b0;
        end else begin
            mclk_ph   <= mclk_ph_nxt;
            rpt_cnt   <= rpt_cnt_nxt;
            sec_cnt   <= sec_cnt_nxt;
            MCLK      <= (mclk_ph_nxt < PH_HALF);
            PULSE_OUT <= (rpt_cnt_nxt == '0);
        end
    end

    // Holdover seconds: only counts while in HOLDOVER, so it starts from zero on entry
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ho_cyc <= '0;
            ho_sec <= '0;
        end else if (state != ST_HOLDOVER) begin
            ho_cyc <= '0;
            ho_sec <= '0;
        end else if (ho_cyc == SEC_LAST) begin
            ho_cyc <= '0;
            ho_sec <= ho_sec + 32'd1;
        end else begin
            ho_cyc <= ho_cyc + 32'd1;
        end
    end

    // State register and registered status decodes, updated on the same edge as the state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= ST_UNLOCKED;
            PPS_LOCKED <= 1'b0;
            HOLDOVER   <= 1'b0;
            PPS_ERR    <= 1'b0;
            PPS_PERIOD <= 32'(CLK_FREQ_HZ);
        end else begin
            state      <= state_nxt;
            PPS_LOCKED <= (state_nxt == ST_LOCKED);
            HOLDOVER   <= (state_nxt == ST_HOLDOVER);
            PPS_ERR    <= err_nxt;
            if (period_ld) begin
                PPS_PERIOD <= sec_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pps_disciplined_timebase.sv
`timescale 1ns/1ps
module tb_pps_disciplined_timebase;

    localparam int F   = 1000;
    localparam int DIV = 4;
    localparam int RR  = 10;
    localparam int TOL = 5;
    localparam int HM  = 3;
    localparam int P   = F / RR;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        GPS_PPS = 1'b0;
    logic        MCLK;
    logic        PULSE_OUT;
    logic        PPS_LOCKED;
    logic        HOLDOVER;
    logic        PPS_ERR;
    logic [31:0] PPS_PERIOD;

    pps_disciplined_timebase #(
        .CLK_FREQ_HZ (F),
        .MCLK_DIV    (DIV),
        .REPORT_RATE (RR),
        .PPS_TOL     (TOL),
        .HOLDOVER_MAX(HM)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .GPS_PPS   (GPS_PPS),
        .MCLK      (MCLK),
        .PULSE_OUT (PULSE_OUT),
        .PPS_LOCKED(PPS_LOCKED),
        .HOLDOVER  (HOLDOVER),
        .PPS_ERR   (PPS_ERR),
        .PPS_PERIOD(PPS_PERIOD)
    );

    always #5 CLK = ~CLK;

    // Cycle index: number of rising edges since reset release
    int cyc = 0;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int          cyc;
        logic        err;
        logic        lock;
        logic        hold;
        logic [31:0] period;
    } ev_t;

    ev_t  ev_q[$];
    int   align_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    int          origin = 0;
    logic        prev_lock = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_period = 32'(F);
    logic        exp_pulse;
    logic        exp_mclk;
    logic        trig;
    ev_t         e_cur;

    // Monitor: strobe/clock grid from expected alignment cycles, status activity against the event queue
    always @(negedge CLK) begin
        if (!nRST) begin
            origin      = 0;
            prev_lock   = 1'b0;
            prev_hold   = 1'b0;
            prev_period = 32'(F);
        end else begin
            if (align_q.size() > 0 && align_q[0] == cyc) begin
                origin = cyc;
                void'(align_q.pop_front());
            end
            exp_pulse = (((cyc - origin) % P) == 0);
            exp_mclk  = (((cyc - origin) % DIV) < 2);
            n_vec++;
            if (PULSE_OUT !== exp_pulse) begin
                n_err++;
                $display("FAIL pulse_out cyc=%0d got=%b exp=%b", cyc, PULSE_OUT, exp_pulse);
            end
            n_vec++;
            if (MCLK !== exp_mclk) begin
                n_err++;
                $display("FAIL mclk cyc=%0d got=%b exp=%b", cyc, MCLK, exp_mclk);
            end
            trig = (PPS_ERR !== 1'b0) || (PPS_LOCKED !== prev_lock) ||
                   (HOLDOVER !== prev_hold) || (PPS_PERIOD !== prev_period);
            if (trig) begin
                n_vec++;
                if (ev_q.size() == 0) begin
                    n_err++;
                    $display("FAIL status_unexpected cyc=%0d got err=%b lock=%b hold=%b period=%0d exp no activity",
                             cyc, PPS_ERR, PPS_LOCKED, HOLDOVER, PPS_PERIOD);
                end else begin
                    e_cur = ev_q.pop_front();
                    if (e_cur.cyc != cyc || PPS_ERR !== e_cur.err || PPS_LOCKED !== e_cur.lock ||
                        HOLDOVER !== e_cur.hold || PPS_PERIOD !== e_cur.period) begin
                        n_err++;
                        $display("FAIL status cyc=%0d got err=%b lock=%b hold=%b period=%0d exp cyc=%0d err=%b lock=%b hold=%b period=%0d",
                                 cyc, PPS_ERR, PPS_LOCKED, HOLDOVER, PPS_PERIOD,
                                 e_cur.cyc, e_cur.err, e_cur.lock, e_cur.hold, e_cur.period);
                    end
                end
            end else if (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
                n_vec++;
                n_err++;
                e_cur = ev_q.pop_front();
                $display("FAIL status_missing cyc=%0d got no activity exp cyc=%0d err=%b lock=%b hold=%b period=%0d",
                         cyc, e_cur.cyc, e_cur.err, e_cur.lock, e_cur.hold, e_cur.period);
            end
            prev_lock   = PPS_LOCKED;
            prev_hold   = HOLDOVER;
            prev_period = PPS_PERIOD;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mclk"},       32'(MCLK),       32'd0);
        chk({tag, "_pulse_out"},  32'(PULSE_OUT),  32'd0);
        chk({tag, "_pps_locked"}, 32'(PPS_LOCKED), 32'd0);
        chk({tag, "_holdover"},   32'(HOLDOVER),   32'd0);
        chk({tag, "_pps_err"},    32'(PPS_ERR),    32'd0);
        chk({tag, "_pps_period"}, PPS_PERIOD,      32'(F));
    endtask

    // Advance to the falling edge of cycle c, bounded by a cycle budget
    task automatic run_until(input int c);
        int guard = 0;
        while (cyc < c && guard < 20000) begin
            @(negedge CLK);
            guard++;
        end
        if (cyc != c) begin
            n_vec++;
            n_err++;
            $display("FAIL run_until got cyc=%0d exp cyc=%0d", cyc, c);
        end
    endtask

    // Raise GPS_PPS so that the DUT aligns on edge a (sampled high first at edge a-3)
    task automatic pps_at(input int a);
        run_until(a - 4);
        GPS_PPS = 1'b1;
        run_until(a - 2);
        GPS_PPS = 1'b0;
    endtask

    task automatic expect_align(input int a);
        align_q.push_back(a);
    endtask

    task automatic expect_ev(input int c, input logic err, input logic lock, input logic hold, input int period);
        ev_t e;
        e.cyc    = c;
        e.err    = err;
        e.lock   = lock;
        e.hold   = hold;
        e.period = 32'(period);
        ev_q.push_back(e);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got cyc=%0d exp completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST    = 1'b0;
        GPS_PPS = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_values("reset");
        @(negedge CLK);
        #1 nRST = 1'b1;

        // Free-run strobes at 100, 200; first edge at odd phase (rpt_cnt 37) moves the grid
        expect_align(238);
        pps_at(238);
        // Second edge one second later: LOCKED, period 1000
        expect_ev(1238, 1'b0, 1'b1, 1'b0, 1000);
        expect_align(1238);
        pps_at(1238);
        // Glitch off the grid: error strobe only, grid and lock untouched
        expect_ev(1548, 1'b1, 1'b1, 1'b0, 1000);
        pps_at(1548);
        expect_align(2238);
        pps_at(2238);
        // Period 1005 then 1006 (sec_cnt 1005, the inclusive upper limit)
        expect_ev(3243, 1'b0, 1'b1, 1'b0, 1005);
        expect_align(3243);
        pps_at(3243);
        expect_ev(4249, 1'b0, 1'b1, 1'b0, 1006);
        expect_align(4249);
        pps_at(4249);
        // Period 1010: timeout first (HOLDOVER), then the late edge re-acquires
        expect_ev(5256, 1'b0, 1'b0, 1'b1, 1006);
        expect_ev(5259, 1'b0, 1'b0, 1'b0, 1006);
        expect_align(5259);
        pps_at(5259);
        expect_ev(6259, 1'b0, 1'b1, 1'b0, 1000);
        expect_align(6259);
        pps_at(6259);
        // PPS stops: HOLDOVER for exactly 3 seconds, then UNLOCKED
        expect_ev(7266, 1'b0, 1'b0, 1'b1, 1000);
        expect_ev(10266, 1'b0, 1'b0, 1'b0, 1000);
        run_until(10400);
        // Relock with a 1003 period, then reset asynchronously mid-LOCKED
        expect_align(10537);
        pps_at(10537);
        expect_ev(11540, 1'b0, 1'b1, 1'b0, 1003);
        expect_align(11540);
        pps_at(11540);
        run_until(11540);
        #2 nRST = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (2) @(negedge CLK);
        #1 nRST = 1'b1;

        // After reset: acquire, out-of-window edge in ACQUIRE, then a valid edge locks
        expect_align(137);
        pps_at(137);
        expect_ev(537, 1'b1, 1'b0, 1'b0, 1000);
        expect_align(537);
        pps_at(537);
        expect_ev(1535, 1'b0, 1'b1, 1'b0, 998);
        expect_align(1535);
        pps_at(1535);
        run_until(1700);

        n_vec++;
        if (ev_q.size() != 0 || align_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover got events=%0d aligns=%0d exp 0", ev_q.size(), align_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
